fpalu_sub_seq: RTL and testbench

FPALU_SUB_SEQ -- requirements
Module: fpalu_sub_seq

---
 rtl/fpalu_sub_seq.sv | 126 ++++++++++++
 tb/tb_fpalu_sub_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: diff = a_in - b_in.
// Truncating, denormals flushed, one alignment or normalization shift per cycle.
module fpalu_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  ea, eb, exp_gap, exp_r;
  logic [23:0] ma, mb;
  logic        sa, sb, swap;
  logic [4:0]  shift_amt, cnt;
  logic        sign_a, sign_b, inf_in;
  logic [24:0] sig_a, sig_b;
  logic        norm_left, norm_last;

  // Operand unpack and magnitude ordering, used only on the accepting edge.
  always_comb begin
    ea        = a_in[30:23];
    eb        = b_in[30:23];
    ma        = (ea == '0) ? '0 : {1'b1, a_in[22:0]};
    mb        = (eb == '0) ? '0 : {1'b1, b_in[22:0]};
    sa        = a_in[31];
    sb        = ~b_in[31];
    swap      = (eb > ea) || ((eb == ea) && (mb > ma));
    exp_gap   = swap ? (eb - ea) : (ea - eb);
    shift_amt = (exp_gap > 8'd25) ? 5'd25 : exp_gap[4:0];
  end

  // Left shift stops once bit 23 lands or the exponent bottoms out at 0.
  assign norm_left = !sig_a[24] && !sig_a[23] && (sig_a != '0) && (exp_r != '0);
  assign norm_last = !norm_left || sig_a[22] || (exp_r == 8'd1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ALIGN;
      ALIGN:   if (cnt <= 5'd1) state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    if (norm_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      exp_r     <= '0;
      sig_a     <= '0;
      sig_b     <= '0;
      cnt       <= '0;
      inf_in    <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_a <= swap ? sb : sa;
          sign_b <= swap ? sa : sb;
          exp_r  <= swap ? eb : ea;
          sig_a  <= {1'b0, swap ? mb : ma};
          sig_b  <= {1'b0, swap ? ma : mb};
          cnt    <= shift_amt;
          inf_in <= (ea == 8'hFF) || (eb == 8'hFF);
        end
        ALIGN: if (cnt != '0) begin
          sig_b <= sig_b >> 1;
          cnt   <= cnt - 5'd1;
        end
        ADD: sig_a <= (sign_a == sign_b) ? (sig_a + sig_b) : (sig_a - sig_b);
        NORM: begin
          if (sig_a[24]) begin
            sig_a <= sig_a >> 1;
            exp_r <= exp_r + 8'd1;
          end else if (norm_left) begin
            sig_a <= sig_a << 1;
            exp_r <= exp_r - 8'd1;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (inf_in || (exp_r == 8'hFF)) begin
            diff      <= {sign_a, 8'hFF, 23'h0};
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (sig_a == '0) begin
            diff      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else if (exp_r == '0) begin
            diff      <= {sign_a, 31'h0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
          end else begin
            diff      <= {sign_a, exp_r, sig_a[22:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpalu_sub_seq.sv
// Bench for fpalu_sub_seq: directed vectors, randomized ops against an
// arithmetic reference model, busy/done-cycle start handling and mid-op reset.
module tb_fpalu_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, overflow, underflow;
  logic [31:0] diff;

  int n_pass = 0;
  int n_total = 0;

  fpalu_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, d;
    logic        ov, un;
    int          lat;
  } vec_t;

  // Reference: exact integer arithmetic on the significands, truncating alignment.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic ov, output logic un,
                       output int lat);
    int unsigned ea, eb, ma, mb, t;
    logic sa, sb, ts;
    int s, e, n;
    longint sum;
    ea = a[30:23]; eb = b[30:23];
    ma = (ea == 0) ? 0 : (32'(a[22:0]) + 32'h800000);
    mb = (eb == 0) ? 0 : (32'(b[22:0]) + 32'h800000);
    sa = a[31]; sb = ~b[31];
    if (eb > ea || (eb == ea && mb > ma)) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      ts = sa; sa = sb; sb = ts;
    end
    s = int'(ea - eb);
    if (s > 25) s = 25;
    mb = mb >> s;
    sum = (sa == sb) ? longint'(ma) + longint'(mb) : longint'(ma) - longint'(mb);
    e = int'(ea); n = 0;
    if (sum >= 64'd16777216) begin
      sum = sum >> 1; e++; n = 1;
    end else begin
      while (sum != 0 && sum < 64'd8388608 && e > 0) begin
        sum = sum << 1; e--; n++;
      end
    end
    lat = 2 + ((s < 1) ? 1 : s) + ((n < 1) ? 1 : n);
    ov = 1'b0; un = 1'b0;
    if (ea == 255 || eb == 255 || e >= 255) begin
      d = {sa, 8'hFF, 23'h0}; ov = 1'b1;
    end else if (sum == 0) begin
      d = '0;
    end else if (e == 0) begin
      d = {sa, 31'h0}; un = 1'b1;
    end else begin
      d = {sa, e[7:0], sum[22:0]};
    end
  endtask

  // Presents one request, scrambles the inputs after acceptance, waits for done.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit got, output logic busy_acc);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; busy_acc = busy;
    a_in = $urandom; b_in = $urandom;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, diff, overflow, underflow} !== 35'd0) begin
      $display("FAIL reset_state: got busy=%b done=%b diff=%h ov=%b un=%b, need all 0",
               busy, done, diff, overflow, underflow);
    end else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[$];
    int lat; bit got; logic bz; logic [31:0] held;
    v.push_back('{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4});
    v.push_back('{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 4});
    v.push_back('{32'h3F800000, 32'h3FC00000, 32'hBF000000, 1'b0, 1'b0, 4});
    v.push_back('{32'h40490FDB, 32'h40490FDB, 32'h00000000, 1'b0, 1'b0, 4});
    v.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 4});
    v.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 28});
    v.push_back('{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 1'b0, 27});
    v.push_back('{32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 4});
    v.push_back('{32'h80C00000, 32'h80800000, 32'h80000000, 1'b0, 1'b1, 4});
    foreach (v[k]) begin
      launch(v[k].a, v[k].b, lat, got, bz);
      n_total++;
      if (bz !== 1'b1) $display("FAIL dir%0d_busy: got %b need 1", k, bz);
      else n_pass++;
      n_total++;
      if (!got) begin
        $display("FAIL dir%0d_timeout: no done within 100 edges, need %0d", k, v[k].lat);
        continue;
      end else n_pass++;
      n_total++;
      if ({diff, overflow, underflow} !== {v[k].d, v[k].ov, v[k].un})
        $display("FAIL dir%0d_result: got %h ov=%b un=%b need %h ov=%b un=%b",
                 k, diff, overflow, underflow, v[k].d, v[k].ov, v[k].un);
      else n_pass++;
      n_total++;
      if (lat !== v[k].lat) $display("FAIL dir%0d_latency: got %0d need %0d", k, lat, v[k].lat);
      else n_pass++;
      held = diff;
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || diff !== v[k].d || busy !== 1'b0)
        $display("FAIL dir%0d_hold: got done=%b busy=%b diff=%h need 0 0 %h",
                 k, done, busy, diff, held);
      else n_pass++;
    end
  endtask

  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int mode;
    mode = $urandom_range(0, 3);
    a = $urandom; b = $urandom;
    case (mode)
      1: begin
        b[31] = a[31];
        b[30:23] = a[30:23] + 8'($urandom_range(0, 1));
      end
      2: begin
        a[30:23] = 8'($urandom_range(1, 3));
        b[30:23] = 8'($urandom_range(1, 3));
        b[31] = a[31];
      end
      3: begin
        if ($urandom_range(0, 1) == 0) a[30:23] = '0;
        else b[30:23] = a[30:23] - 8'($urandom_range(20, 30));
      end
      default: ;
    endcase
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) b[30] = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a, b, d; logic ov, un, bz; int lat, mlat; bit got;
    for (int k = 0; k < 300; k++) begin
      gen(a, b);
      model(a, b, d, ov, un, mlat);
      launch(a, b, lat, got, bz);
      n_total++;
      if (!got) begin
        $display("FAIL rnd%0d_timeout: a=%h b=%h no done, need latency %0d", k, a, b, mlat);
        continue;
      end else n_pass++;
      n_total++;
      if (diff !== d) $display("FAIL rnd%0d_diff: a=%h b=%h got %h need %h", k, a, b, diff, d);
      else n_pass++;
      n_total++;
      if ({overflow, underflow} !== {ov, un})
        $display("FAIL rnd%0d_flags: a=%h b=%h got ov=%b un=%b need ov=%b un=%b",
                 k, a, b, overflow, underflow, ov, un);
      else n_pass++;
      n_total++;
      if (lat !== mlat) $display("FAIL rnd%0d_latency: a=%h b=%h got %0d need %0d", k, a, b, lat, mlat);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore;
    int lat; bit got, extra;
    @(negedge clk);
    a_in = 32'h4B800000; b_in = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 7 || i == 15 || i == 20);
      a_in = 32'h3F800000; b_in = $urandom;
      @(posedge clk); #1;
      lat++;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    n_total++;
    if (!got || lat !== 27 || diff !== 32'h4B800000)
      $display("FAIL busy_ignore: got done=%b lat=%0d diff=%h need 1 27 4b800000", got, lat, diff);
    else n_pass++;
    extra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra = 1'b1;
    end
    n_total++;
    if (extra !== 1'b0) $display("FAIL no_queue: got activity=%b need 0", extra);
    else n_pass++;
  endtask

  task automatic test_done_cycle;
    int first, second, third;
    @(negedge clk);
    a_in = 32'h40400000; b_in = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; third = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
        else if (third == 0) third = i;
      end
      if (i == 13) start = 1'b0;
    end
    n_total++;
    if (first !== 4 || second !== 9 || third !== 14)
      $display("FAIL done_cycle_start: got done at edges %0d,%0d,%0d need 4,9,14", first, second, third);
    else n_pass++;
    n_total++;
    if (diff !== 32'h40000000) $display("FAIL done_cycle_diff: got %h need 40000000", diff);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat; bit got, seen; logic bz;
    @(negedge clk);
    a_in = 32'h4B800000; b_in = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, diff, overflow, underflow} !== 35'd0)
      $display("FAIL reset_mid: got busy=%b done=%b diff=%h ov=%b un=%b need all 0",
               busy, done, diff, overflow, underflow);
    else n_pass++;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_abort: got done/busy activity=%b need 0", seen);
    else n_pass++;
    launch(32'h40400000, 32'h3F800000, lat, got, bz);
    n_total++;
    if (!got || bz !== 1'b1 || lat !== 4 || diff !== 32'h40000000)
      $display("FAIL after_reset: got done=%b busy=%b lat=%0d diff=%h need 1 1 4 40000000",
               got, bz, lat, diff);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_done_cycle;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
